c16_memory: RTL and testbench



---
 rtl/c16_memory.sv | 57 +++++
 tb/tb_c16_memory.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/c16_memory.sv
// c16 main instruction/data store: single-port synchronous word RAM with a
// registered read port (one-cycle latency) and a zero-latency write.
module c16_memory #(
    parameter int    DATA_WIDTH = 16,
    parameter int    ADDR_WIDTH = 16,
    parameter int    DEPTH_BITS = 12,
    parameter string INIT_FILE  = ""
) (
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic                  clk,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  rden,
    input  logic                  wren,
    output logic [DATA_WIDTH-1:0] q,
    input  logic                  reset
);

    localparam int DEPTH = 1 << DEPTH_BITS;

    typedef logic [DATA_WIDTH-1:0] mem_t [DEPTH];

    // Configuration-time image: all zeros.
    mem_t                  mem = '{default: '0};
    logic [DATA_WIDTH-1:0] q_reg = '0;
    logic [DEPTH_BITS-1:0] index;

    // Upper address bits (including the MMIO window bit) alias onto the array.
    assign index = address[DEPTH_BITS-1:0];

    generate
        if (ADDR_WIDTH > DEPTH_BITS) begin : g_alias
            logic unused_upper_address;
            assign unused_upper_address = ^address[ADDR_WIDTH-1:DEPTH_BITS];
        end
    endgenerate

    // NOTE: the array has no reset branch; reset only gates the write so
    // contents survive it and the array still maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wren && !reset) begin
            mem[index] <= data;
        end
    end

    // NOTE: non-blocking assignments make a same-address read return the
    // pre-write word, independent of the order of the two processes.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_reg <= '0;
        end else if (rden) begin
            q_reg <= mem[index];
        end
    end

    assign q = q_reg;

endmodule

// File: tb/tb_c16_memory.sv
// Self-checking bench for c16_memory: a reference model computes the expected
// q for each cycle, queues it, and the value is compared after the clock edge.
module tb_c16_memory;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] address = '0;
    logic [15:0] data = '0;
    logic        rden = 1'b0;
    logic        wren = 1'b0;
    logic [15:0] q;

    int compared   = 0;
    int mismatched = 0;

    logic [15:0] model_mem [4096];
    logic [15:0] model_q;
    logic [15:0] sb [$];

    c16_memory #(
        .DATA_WIDTH(16),
        .ADDR_WIDTH(16),
        .DEPTH_BITS(12),
        .INIT_FILE ("")
    ) dut (
        .address(address),
        .clk    (clk),
        .data   (data),
        .rden   (rden),
        .wren   (wren),
        .q      (q),
        .reset  (reset)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("FAIL %s: got 0x%04h, want 0x%04h", tag, observed, expected);
        end
    endtask

    // One clock cycle: drive inputs, queue the model's q, compare after the edge.
    task automatic step(input string tag, input logic rst, input logic rd, input logic wr,
                        input logic [15:0] a, input logic [15:0] d);
        logic [15:0] expected;
        reset   = rst;
        rden    = rd;
        wren    = wr;
        address = a;
        data    = d;
        if (rst) begin
            model_q = '0;
        end else if (rd) begin
            model_q = model_mem[a[11:0]];
        end
        if (!rst && wr) begin
            model_mem[a[11:0]] = d;
        end
        sb.push_back(model_q);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            expected = sb.pop_front();
            check(tag, q, expected);
        end
        reset = 1'b0;
        rden  = 1'b0;
        wren  = 1'b0;
    endtask

    task automatic write(input logic [15:0] a, input logic [15:0] d);
        step("write", 1'b0, 1'b0, 1'b1, a, d);
    endtask

    task automatic read(input string tag, input logic [15:0] a);
        step(tag, 1'b0, 1'b1, 1'b0, a, 16'h0000);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 4096; i++) model_mem[i] = '0;
        model_q = '0;

        #1;
        check("powerup_q", q, 16'h0000);

        step("reset_idle", 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        check("reset_idle_q", q, 16'h0000);

        read("unwritten", 16'h0ABC);
        check("unwritten_zero", q, 16'h0000);

        write(16'h0010, 16'hBEEF);
        read("wr_then_rd", 16'h0010);
        check("wr_then_rd_val", q, 16'hBEEF);

        write(16'h0011, 16'h1234);
        check("read_hold", q, 16'hBEEF);
        read("rd_0011", 16'h0011);
        check("rd_0011_val", q, 16'h1234);

        write(16'h0020, 16'h0001);
        step("rdw_same", 1'b0, 1'b1, 1'b1, 16'h0020, 16'h0002);
        check("rdw_old_data", q, 16'h0001);
        read("rdw_after", 16'h0020);
        check("rdw_new_data", q, 16'h0002);

        write(16'h0005, 16'h5A5A);
        read("alias_1005", 16'h1005);
        check("alias_val", q, 16'h5A5A);
        write(16'h8007, 16'hC0DE);
        read("mmio_bit_ignored", 16'h0007);
        check("mmio_bit_val", q, 16'hC0DE);

        read("pre_reset", 16'h0010);
        check("pre_reset_val", q, 16'hBEEF);
        step("reset_wr", 1'b1, 1'b0, 1'b1, 16'h0010, 16'hFFFF);
        check("reset_q_zero", q, 16'h0000);
        read("post_reset", 16'h0010);
        check("post_reset_kept", q, 16'hBEEF);

        write(16'h0000, 16'h000A);
        write(16'h0001, 16'h000B);
        write(16'h0002, 16'h000C);
        write(16'h0003, 16'h000D);
        read("stream0", 16'h0000);
        check("stream0_val", q, 16'h000A);
        read("stream1", 16'h0001);
        check("stream1_val", q, 16'h000B);
        read("stream2", 16'h0002);
        check("stream2_val", q, 16'h000C);
        read("stream3", 16'h0003);
        check("stream3_val", q, 16'h000D);

        step("rdw_diff", 1'b0, 1'b1, 1'b1, 16'h0000, 16'h7777);
        check("rdw_diff_rd", q, 16'h000A);
        read("rdw_diff_after", 16'h0001);
        check("rdw_diff_rd2", q, 16'h000B);
        read("rdw_diff_wr", 16'h0000);
        check("rdw_diff_wr_val", q, 16'h7777);

        for (int i = 0; i < 60; i++) begin
            logic [15:0] a;
            a = {$urandom_range(0, 65535)} & 16'hF03F;
            step("random", ($urandom_range(0, 15) == 0), $urandom_range(0, 1) == 1,
                 $urandom_range(0, 1) == 1, a, 16'($urandom_range(0, 65535)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
